canny_frame_controller: RTL
===========================

Name: canny_frame_controller

Overview:
- Sequences one full frame through the edge pipeline: pixel_loader → gaussian_filter → pixel_loader → gradient_calculation → pixel_loader pair → non_max_suppression.
- On start, pulses a pipeline clear, then streams every pixel from the frame buffer in raster order with a 1-cycle read latency.
- Counts non_max_suppression output valids and reports done, or reports error on drain timeout or output overflow.
- Replaces bench-driven feeding of the pipeline in the integrated top.

Parameters:
- IMG_W, 512, frame width in pixels.
- IMG_H, 512, frame height in pixels.
- ADDR_W, 18, frame buffer address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H.
- EXPECTED_OUT, (IMG_W-6)*(IMG_H-6), number of NMS outputs per frame. Three 3x3 window stages each trim a 1-pixel border, giving 256036 at the default.
- DRAIN_TIMEOUT, 4096, maximum cycles allowed with no sink_valid after the last pixel is issued.

Ports:
- clk  in  1  clock.
- rstN  in  1  asynchronous active-low reset.
- start  in  1  single-cycle frame start request; ignored while busy.
- abort  in  1  cancels the frame in progress.
- pause  in  1  while high, no new read is issued in STREAM.
- mem_rd_en  out  1  frame buffer read strobe.
- mem_rd_addr  out  ADDR_W  frame buffer read address.
- mem_rd_data  in  8  read data, valid exactly 1 cycle after mem_rd_en.
- pipe_clr  out  1  one-cycle synchronous clear to all pipeline stages.
- pixel_out  out  8  pixel to pl1.pixel_in.
- pixel_out_valid  out  1  to pl1.pixel_in_valid.
- sink_valid  in  1  nms_valid from non_max_suppression.
- busy  out  1  high in CLEAR, STREAM and DRAIN.
- done  out  1  one-cycle pulse on successful frame completion.
- error  out  1  sticky error flag; cleared by the next accepted start.
- out_count  out  ADDR_W+1  number of sink_valid pulses in the current frame.

Behaviour:
- Reset (rstN low, async): FSM goes to IDLE. All outputs 0: mem_rd_addr=0, out_count=0, error=0, pixel_out=0. Drain timer is cleared.
- Reset mid-frame discards all progress. The pipeline is not cleared until the next start.
- FSM states: IDLE, CLEAR, STREAM, DRAIN, DONE.
- IDLE:
  - start → CLEAR.
  - Accepting start clears error and out_count and sets mem_rd_addr=0.
- CLEAR: pipe_clr=1 for exactly one cycle, no reads issued, then → STREAM.
- STREAM:
  - Each cycle with pause=0: mem_rd_en=1 at mem_rd_addr, and mem_rd_addr increments the following cycle.
  - With pause=1: mem_rd_en=0 and the address holds.
  - When address IMG_W*IMG_H-1 is issued → DRAIN. The address does not wrap; it holds at the last value.
- Output path:
  - pixel_out = mem_rd_data, and pixel_out_valid = mem_rd_en delayed 1 cycle.
  - Total latency from start to the first pixel_out_valid is 3 cycles with pause=0: CLEAR, read, data.
  - Pause gaps propagate as gaps in pixel_out_valid.
- Output counting:
  - out_count increments on every sink_valid in STREAM or DRAIN.
  - sink_valid is ignored in IDLE and DONE.
- DRAIN:
  - The drain timer counts cycles and resets to 0 on each sink_valid.
  - out_count reaching EXPECTED_OUT → DONE.
  - The timer reaching DRAIN_TIMEOUT → error=1, then → IDLE with no done pulse.
- Overflow: a sink_valid while out_count==EXPECTED_OUT, in any counting state, sets error=1 and → IDLE.
- Early completion: if out_count reaches EXPECTED_OUT while still in STREAM, the frame stays in STREAM until all reads are issued, then → DRAIN, then immediately → DONE.
- DONE: done=1 for one cycle, busy=0, → IDLE. out_count holds its final value until the next start.
- Abort:
  - abort in CLEAR, STREAM or DRAIN → IDLE next cycle.
  - No done pulse and error is unchanged. mem_rd_en and pixel_out_valid drop the following cycle.
  - abort takes priority over all other transitions in the same cycle.
- Start/abort collision: start together with abort in IDLE is ignored.
- Width rules:
  - out_count saturates at EXPECTED_OUT; overflow is reported through error.
  - The drain timer is clog2(DRAIN_TIMEOUT)+1 bits.

Test Plan:
- Nominal frame (IMG_W=IMG_H=8, EXPECTED_OUT=4, memory holds addr[7:0]):
  - start → pipe_clr pulse, then 64 consecutive reads at addresses 0..63.
  - pixel_out_valid is high for 64 cycles with pixel_out=0..63.
  - Inject 4 sink_valid → done pulses once, out_count=4, error=0.
- Pause: hold pause high for 5 cycles mid-stream at address 20 → mem_rd_addr holds at 20 with 5-cycle gaps in pixel_out_valid. Total valid count is still 64 and the pixel order is intact.
- Drain timeout (DRAIN_TIMEOUT=16): inject 3 of 4 sink_valid → 16 idle cycles after the last one, error=1, busy=0, no done. The next start clears error.
- Overflow: inject 5 sink_valid → error=1 on the 5th, FSM returns to IDLE, out_count=4.
- Abort at address 30: busy=0 within 1 cycle, no further mem_rd_en, no done. A subsequent start restarts from address 0 with a fresh pipe_clr.
- Async reset mid-DRAIN: all outputs 0 immediately. start while busy=1 has no effect on the address sequence.

Source files
------------

// File: rtl/canny_frame_controller.sv
// Frame sequencer for the Canny edge pipeline: clears the pipeline, streams the
// frame buffer in raster order, then counts NMS outputs until done/timeout/overflow.
module canny_frame_controller #(
    parameter int IMG_W         = 512,
    parameter int IMG_H         = 512,
    parameter int ADDR_W        = 18,
    parameter int EXPECTED_OUT  = (IMG_W - 6) * (IMG_H - 6),
    parameter int DRAIN_TIMEOUT = 4096
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic              start,
    input  logic              abort,
    input  logic              pause,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [7:0]        mem_rd_data,
    output logic              pipe_clr,
    output logic [7:0]        pixel_out,
    output logic              pixel_out_valid,
    input  logic              sink_valid,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   out_count
);

    // state  | meaning
    // IDLE   | waiting for start
    // CLEAR  | one-cycle pipeline clear
    // STREAM | issuing frame buffer reads
    // DRAIN  | all reads issued, waiting for remaining NMS outputs
    // DONE   | one-cycle completion pulse
    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam int                TMR_W     = $clog2(DRAIN_TIMEOUT) + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);
    localparam logic [ADDR_W:0]   EXP_CNT   = (ADDR_W + 1)'(EXPECTED_OUT);
    localparam logic [TMR_W-1:0]  TMR_LIMIT = TMR_W'(DRAIN_TIMEOUT);

    state_t            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   cnt_q;
    logic [TMR_W-1:0]  tmr_q;
    logic              err_q;
    logic              clr_q;
    logic              done_q;
    logic              busy_q;
    logic              vld_q;

    logic [ADDR_W:0]   cnt_d;
    logic [TMR_W-1:0]  tmr_d;
    logic              rd_issue;
    logic              overflow;

    assign cnt_d    = cnt_q + 1'b1;
    assign tmr_d    = tmr_q + 1'b1;
    assign overflow = sink_valid && (cnt_q == EXP_CNT);

    // The read strobe follows pause in the same cycle so a paused cycle never issues a read.
    assign rd_issue = (state_q == S_STREAM) && !pause;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            tmr_q   <= '0;
            err_q   <= 1'b0;
            clr_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            vld_q   <= 1'b0;
        end else begin
            clr_q  <= 1'b0;
            done_q <= 1'b0;
            // A read issued in the abort cycle is discarded so valid drops with busy.
            vld_q  <= rd_issue && !abort;
            case (state_q)
                S_IDLE: begin
                    if (start && !abort) begin
                        state_q <= S_CLEAR;
                        clr_q   <= 1'b1;
                        busy_q  <= 1'b1;
                        err_q   <= 1'b0;
                        cnt_q   <= '0;
                        addr_q  <= '0;
                        tmr_q   <= '0;
                    end
                end
                S_CLEAR: begin
                    if (abort) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (abort) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else if (overflow) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        err_q   <= 1'b1;
                    end else begin
                        if (sink_valid) begin
                            cnt_q <= cnt_d;
                        end
                        if (!pause) begin
                            if (addr_q == LAST_ADDR) begin
                                state_q <= S_DRAIN;
                                tmr_q   <= '0;
                            end else begin
                                addr_q <= addr_q + 1'b1;
                            end
                        end
                    end
                end
                S_DRAIN: begin
                    if (abort) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else if (overflow) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        err_q   <= 1'b1;
                    end else if (sink_valid) begin
                        cnt_q <= cnt_d;
                        tmr_q <= '0;
                        if (cnt_d == EXP_CNT) begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end else if (cnt_q == EXP_CNT) begin
                        // All outputs arrived while still streaming.
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (tmr_d == TMR_LIMIT) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        err_q   <= 1'b1;
                    end else begin
                        tmr_q <= tmr_d;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign mem_rd_en       = rd_issue;
    assign mem_rd_addr     = addr_q;
    assign pipe_clr        = clr_q;
    assign pixel_out_valid = vld_q;
    assign pixel_out       = vld_q ? mem_rd_data : 8'd0;
    assign busy            = busy_q;
    assign done            = done_q;
    assign error           = err_q;
    assign out_count       = cnt_q;

endmodule
